// File: rtl/column_renderer.sv
// Read side of the trace buffer: prefetches one column height two clocks ahead of the beam
// and turns (height, h, v) into registered 2-bit-per-channel RGB for the active area.
module column_renderer #(
    parameter int unsigned H_VIEW     = 640,
    parameter int unsigned H_TOTAL    = 800,
    parameter int unsigned V_VIEW     = 480,
    parameter int unsigned V_TOTAL    = 525,
    parameter int unsigned HORIZON    = 240,
    parameter int unsigned MAX_HEIGHT = 240,
    parameter logic [5:0]  CEIL_RGB   = 6'b010101,
    parameter logic [5:0]  FLOOR_RGB  = 6'b101010,
    parameter logic [5:0]  WALL_RGB   = 6'b000011
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [9:0] i_h,
    input  logic [9:0] i_v,
    input  logic       i_visible,
    output logic [9:0] o_buf_addr,
    output logic       o_buf_rd_en,
    input  logic [7:0] i_buf_data,
    output logic [1:0] o_red,
    output logic [1:0] o_green,
    output logic [1:0] o_blue
);

    localparam logic [9:0] LP_H_WRAP  = 10'(H_TOTAL - 2);
    localparam logic [9:0] LP_H_VIEW  = 10'(H_VIEW);
    localparam logic [9:0] LP_V_VIEW  = 10'(V_VIEW);
    localparam logic [9:0] LP_V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0] LP_HORIZON = 10'(HORIZON);
    localparam logic [7:0] LP_MAX_HGT = 8'(MAX_HEIGHT);

    typedef enum logic [1:0] {StVblank, StPrefetch, StActive, StHblank} state_e;

    // w_state_next classifies the current clock; r_state remembers the previous one,
    // so it says whether buf_data on this clock answers a read.
    state_e     r_state;
    state_e     w_state_next;
    logic       w_wrap;
    logic [9:0] w_fetch_col;
    logic [9:0] w_fetch_line;
    logic       w_read;
    logic       w_issued;
    logic [7:0] w_clamped;
    logic [9:0] w_height;
    logic       w_wall;
    logic [5:0] w_colour;
    logic [7:0] r_hgt;
    logic       r_hv;
    logic [5:0] r_rgb;

    always_comb begin
        w_wrap       = (i_h >= LP_H_WRAP);
        w_fetch_col  = w_wrap ? (i_h - LP_H_WRAP) : (i_h + 10'd2);
        w_fetch_line = i_v;
        if (w_wrap) begin
            w_fetch_line = (i_v == LP_V_LAST) ? 10'd0 : (i_v + 10'd1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= StVblank;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = StHblank;
        if (w_fetch_line >= LP_V_VIEW) begin
            w_state_next = StVblank;
        end else if (w_wrap) begin
            w_state_next = StPrefetch;
        end else if (w_fetch_col < LP_H_VIEW) begin
            w_state_next = StActive;
        end
    end

    always_comb begin
        w_read      = !i_reset && (w_state_next == StPrefetch || w_state_next == StActive);
        w_issued    = (r_state == StPrefetch || r_state == StActive);
        o_buf_rd_en = w_read;
        o_buf_addr  = w_read ? w_fetch_col : 10'd0;
    end

    always_comb begin
        w_clamped = (i_buf_data > LP_MAX_HGT) ? LP_MAX_HGT : i_buf_data;
        w_height  = r_hv ? {2'b00, r_hgt} : 10'd0;
        if (i_v < LP_HORIZON) begin
            w_wall   = (i_v > (LP_HORIZON - w_height));
            w_colour = w_wall ? WALL_RGB : CEIL_RGB;
        end else begin
            w_wall   = ((i_v - LP_HORIZON) < w_height);
            w_colour = w_wall ? WALL_RGB : FLOOR_RGB;
        end
    end

    // Stage 1 captures the fetched height; stage 2 colours the beam's current pixel.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_hgt <= 8'd0;
            r_hv  <= 1'b0;
            r_rgb <= 6'd0;
        end else begin
            r_hgt <= w_issued ? w_clamped : 8'd0;
            r_hv  <= w_issued;
            r_rgb <= i_visible ? w_colour : 6'd0;
        end
    end

    assign o_red   = r_rgb[5:4];
    assign o_green = r_rgb[3:2];
    assign o_blue  = r_rgb[1:0];

endmodule

// File: tb/tb_column_renderer.sv
// Bench for column_renderer: a trace-buffer RAM model, a per-clock reference of the fetch
// strobe and pixel colour, and literal expectations at the notable columns and lines.
module tb_column_renderer;

    localparam logic [5:0] CEIL  = 6'b010101;
    localparam logic [5:0] FLOOR = 6'b101010;
    localparam logic [5:0] WALL  = 6'b000011;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] h;
    logic [9:0] v;
    logic       visible;
    logic [9:0] buf_addr;
    logic       buf_rd_en;
    logic [7:0] buf_data;
    logic [1:0] red;
    logic [1:0] green;
    logic [1:0] blue;

    logic [7:0] mem [0:639];
    logic [5:0] cap [0:799];
    int         cap_v = -1;
    bit         seg_new;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    column_renderer dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_h         (h),
        .i_v         (v),
        .i_visible   (visible),
        .o_buf_addr  (buf_addr),
        .o_buf_rd_en (buf_rd_en),
        .i_buf_data  (buf_data),
        .o_red       (red),
        .o_green     (green),
        .o_blue      (blue)
    );

    // RAM answers one clock after a read; otherwise it drives tall junk that must be ignored.
    always @(posedge clk) begin
        if (buf_rd_en && buf_addr < 10'd640) buf_data <= mem[buf_addr];
        else                                  buf_data <= 8'hF0 | 8'($urandom);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Colour of pixel (col,line) from the column height alone.
    function automatic logic [5:0] model_pix(input int hgt, input int line);
        int  hh;
        bit  wall;
        hh   = (hgt > 240) ? 240 : hgt;
        wall = (line < 240) ? (line + hh > 240) : (line - 240 < hh);
        if (wall) return WALL;
        return (line < 240) ? CEIL : FLOOR;
    endfunction

    int p_h = 0;
    int p_v = 0;
    bit p_vis = 0;
    bit p_rst = 0;
    int cnt = -100;

    always @(negedge clk) begin : cmp
        int         fc;
        int         fl;
        int         c_next;
        bit         erd;
        logic [5:0] exp_rgb;
        logic [5:0] act_rgb;
        fc  = (int'(h) + 2) % 800;
        fl  = (h >= 10'd798) ? (int'(v) + 1) % 525 : int'(v);
        erd = !reset && fc < 640 && fl < 480;
        chk($sformatf("rd_en h=%0d v=%0d", h, v), int'(buf_rd_en), int'(erd));
        chk($sformatf("addr h=%0d v=%0d", h, v), int'(buf_addr), erd ? fc : 0);
        act_rgb = {red, green, blue};
        c_next  = reset ? -1 : (seg_new ? 0 : cnt + 1);
        if (p_rst) begin
            chk($sformatf("rgb after reset h=%0d v=%0d", p_h, p_v), int'(act_rgb), 0);
        end else if (c_next >= 3) begin
            exp_rgb = (p_vis && p_h < 640) ? model_pix(int'(mem[p_h]), p_v) : 6'd0;
            chk($sformatf("rgb h=%0d v=%0d", p_h, p_v), int'(act_rgb), int'(exp_rgb));
        end
        if (p_v == cap_v && p_h < 800) cap[p_h] <= act_rgb;
        cnt   <= c_next;
        p_h   <= int'(h);
        p_v   <= int'(v);
        p_vis <= visible;
        p_rst <= reset;
    end

    task automatic step(input int hh, input int vv, input bit rst, input bit fresh);
        h       = 10'(hh);
        v       = 10'(vv);
        visible = (hh < 640 && vv < 480);
        reset   = rst;
        seg_new = fresh;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int v0, input int h0, input int n, input bit fresh);
        int hh;
        int vv;
        hh = h0;
        vv = v0;
        for (int i = 0; i < n; i++) begin
            step(hh, vv, 1'b0, fresh && i == 0);
            hh++;
            if (hh == 800) begin
                hh = 0;
                vv = (vv + 1) % 525;
            end
        end
    endtask

    task automatic probe(input int hh, input int vv, input int erd, input int eaddr);
        h       = 10'(hh);
        v       = 10'(vv);
        visible = (hh < 640 && vv < 480);
        reset   = 1'b0;
        seg_new = 1'b1;
        #1;
        chk($sformatf("probe rd_en h=%0d v=%0d", hh, vv), int'(buf_rd_en), erd);
        chk($sformatf("probe addr h=%0d v=%0d", hh, vv), int'(buf_addr), eaddr);
        @(posedge clk);
        #1;
    endtask

    initial begin
        h       = 10'd0;
        v       = 10'd0;
        visible = 1'b0;
        reset   = 1'b1;
        seg_new = 1'b1;
        for (int i = 0; i < 640; i++) mem[i] = 8'(i);

        // Reset state
        step(0, 0, 1'b1, 1'b1);
        step(0, 0, 1'b1, 1'b1);
        chk("reset rgb", int'({red, green, blue}), 0);
        chk("reset rd_en", int'(buf_rd_en), 0);
        chk("reset addr", int'(buf_addr), 0);

        // Data = column index, line 100
        cap_v = 100;
        run(99, 796, 805, 1'b1);
        chk("v100 col0", int'(cap[0]), int'(CEIL));
        chk("v100 col40", int'(cap[40]), int'(CEIL));
        chk("v100 col140", int'(cap[140]), int'(CEIL));
        chk("v100 col141", int'(cap[141]), int'(WALL));
        chk("v100 col255", int'(cap[255]), int'(WALL));
        chk("v100 col256", int'(cap[256]), int'(CEIL));

        // Fetch addressing
        probe(798, 9, 1, 0);
        probe(799, 9, 1, 1);
        probe(637, 9, 1, 639);
        probe(638, 9, 0, 0);
        probe(798, 479, 0, 0);
        probe(799, 524, 1, 1);
        probe(100, 500, 0, 0);

        // Clamp: single tall column 5
        for (int i = 0; i < 640; i++) mem[i] = 8'd0;
        mem[5] = 8'd255;
        cap_v = 0;   run(524, 796, 12, 1'b1);
        chk("c5 v0", int'(cap[5]), int'(CEIL));
        cap_v = 1;   run(0, 796, 12, 1'b1);
        chk("c5 v1", int'(cap[5]), int'(WALL));
        chk("c4 v1", int'(cap[4]), int'(CEIL));
        cap_v = 478; run(477, 796, 12, 1'b1);
        chk("c5 v478", int'(cap[5]), int'(WALL));
        cap_v = 479; run(478, 796, 12, 1'b1);
        chk("c5 v479", int'(cap[5]), int'(WALL));
        chk("c6 v479", int'(cap[6]), int'(FLOOR));

        // All heights zero around the horizon
        mem[5] = 8'd0;
        cap_v = 239; run(238, 796, 806, 1'b1);
        chk("zero v239", int'(cap[100]), int'(CEIL));
        cap_v = 240; run(239, 796, 806, 1'b1);
        chk("zero v240", int'(cap[100]), int'(FLOOR));

        // Vertical blanking and frame wrap with arbitrary data
        for (int i = 0; i < 640; i++) mem[i] = 8'($urandom);
        cap_v = -1;
        run(479, 600, 1810, 1'b1);
        run(523, 700, 910, 1'b1);

        // Reset mid-line with every column full height
        for (int i = 0; i < 640; i++) mem[i] = 8'hFF;
        cap_v = 50;
        run(49, 796, 304, 1'b1);
        step(300, 50, 1'b1, 1'b0);
        run(50, 301, 20, 1'b0);
        chk("rst c299", int'(cap[299]), int'(WALL));
        chk("rst c300", int'(cap[300]), 0);
        chk("rst c301", int'(cap[301]), int'(CEIL));
        chk("rst c302", int'(cap[302]), int'(CEIL));
        chk("rst c303", int'(cap[303]), int'(WALL));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
